// File: rtl/trigger_capture_if.sv
// trigger_capture_if: host/fabric-facing signals of the trigger capture block.
// The master drives events, update and cnt_sel. The slave (trigger_capture)
// returns the snapshot outputs.
interface trigger_capture_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8,
   parameter int SEL_W = 4
);
   logic [WIDTH-1:0] ev_in;
   logic             update;
   logic [SEL_W-1:0] cnt_sel;
   logic [WIDTH-1:0] snap_out;
   logic [WIDTH-1:0] overrun_out;
   logic             snap_valid;
   logic [CNT_W-1:0] cnt_out;
   logic             any_pending;

   modport master (
      output ev_in, update, cnt_sel,
      input  snap_out, overrun_out, snap_valid, cnt_out, any_pending
   );

   modport slave (
      input  ev_in, update, cnt_sel,
      output snap_out, overrun_out, snap_valid, cnt_out, any_pending
   );
endinterface

// File: rtl/trigger_capture.sv
// trigger_capture: sticky per-bit event collector with windowed snapshots.
// Each event bit latches into a pending bit and a saturating counter. An update
// closes the window: pending, overrun and counts move into hold registers, and
// the live state restarts from the events seen in the update cycle.
// Optional macro TRIGCAP_EDGE_EN: only rising edges of ev_in count as events.
// Without the macro, every high cycle counts as an event.

// One event bit: live pending/overrun/count state plus its snapshot copy.
module trigger_capture_lane #(
   parameter int CNT_W = 8
) (
   input  logic             sys_clk,
   input  logic             reset,
   input  logic             ev,
   input  logic             update,
   output logic             pending,
   output logic             snap,
   output logic             ovr_snap,
   output logic [CNT_W-1:0] snap_cnt
);
   logic             ovr_pend;
   logic [CNT_W-1:0] cnt;

   // Live window state and snapshot. An update wins over accumulation, and
   // the update-cycle event seeds the new window.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         pending  <= 1'b0;
         ovr_pend <= 1'b0;
         cnt      <= '0;
         snap     <= 1'b0;
         ovr_snap <= 1'b0;
         snap_cnt <= '0;
      end else if (update) begin
         snap     <= pending;
         ovr_snap <= ovr_pend;
         snap_cnt <= cnt;
         pending  <= ev;
         ovr_pend <= 1'b0;
         cnt      <= {{(CNT_W-1){1'b0}}, ev};
      end else if (ev) begin
         if (pending) ovr_pend <= 1'b1;
         pending <= 1'b1;
         if (cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
      end
   end
endmodule

module trigger_capture #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8,
   parameter int SEL_W = 4
) (
   input logic               sys_clk,
   input logic               reset,
   trigger_capture_if.slave  bus
);
   localparam int STAGES = 1;
   localparam int NSEL   = 2 ** SEL_W;

   logic [WIDTH-1:0]            ev;
   logic [WIDTH-1:0]            pending;
   logic [WIDTH-1:0]            snap;
   logic [WIDTH-1:0]            ovr_snap;
   logic [WIDTH-1:0][CNT_W-1:0] snap_cnt;
   logic [NSEL-1:0][CNT_W-1:0]  cnt_tbl;
   logic [STAGES:0]             vld_pipe;
   logic [CNT_W-1:0]            cnt_q;

`ifdef TRIGCAP_EDGE_EN
   logic [WIDTH-1:0] ev_d;

   // Delayed copy of ev_in for rising-edge detection. It resets low, so a
   // level already high at reset release counts once.
   always_ff @(posedge sys_clk) begin
      if (reset) ev_d <= '0;
      else       ev_d <= bus.ev_in;
   end

   assign ev = bus.ev_in & ~ev_d;
`else
   assign ev = bus.ev_in;
`endif

   for (genvar g = 0; g < WIDTH; g++) begin : g_lane
      trigger_capture_lane #(.CNT_W(CNT_W)) u_lane (
         .sys_clk  (sys_clk),
         .reset    (reset),
         .ev       (ev[g]),
         .update   (bus.update),
         .pending  (pending[g]),
         .snap     (snap[g]),
         .ovr_snap (ovr_snap[g]),
         .snap_cnt (snap_cnt[g])
      );
   end

   // Selector table padded to the full cnt_sel range. Selects beyond WIDTH
   // read zero without a runtime compare.
   for (genvar g = 0; g < NSEL; g++) begin : g_tbl
      if (g < WIDTH) begin : g_real
         assign cnt_tbl[g] = snap_cnt[g];
      end else begin : g_pad
         assign cnt_tbl[g] = '0;
      end
   end

   assign vld_pipe[0] = bus.update;

   // Snapshot-valid pulse trails update by one cycle, in line with the
   // snapshot registers.
   always_ff @(posedge sys_clk) begin
      if (reset) vld_pipe[STAGES:1] <= '0;
      else       vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
   end

   // Registered count readback: one cycle from cnt_sel or snapshot change.
   always_ff @(posedge sys_clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_tbl[bus.cnt_sel];
   end

   assign bus.snap_out    = snap;
   assign bus.overrun_out = ovr_snap;
   assign bus.snap_valid  = vld_pipe[STAGES];
   assign bus.cnt_out     = cnt_q;
   assign bus.any_pending = |pending;
endmodule

// File: doc/trigger_capture.md
Name: trigger_capture

Overview:
- Fabric-side collector for event pulses that the host reads back in batches.
- Per-bit event pulses from fabric logic (counter-equals flags, threshold hits) latch into sticky pending bits. Events are also counted per bit.
- A single-cycle update request, normally a trigger-in bit from the host, snapshots the pending bits, overrun flags and counts into stable registers, clears them and starts a new window.
- The snapshot registers feed wire-out endpoints. The entire block runs on the one sys_clk domain.

Parameters:
- WIDTH, 16, number of event bits.
- CNT_W, 8, width of each per-bit saturating event counter.
- SEL_W, 4, width of cnt_sel; must satisfy 2^SEL_W >= WIDTH.

Ports:
- sys_clk  input  1  sole clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- ev_in  input  WIDTH  event inputs; per-bit event definition is given under Optional Feature.
- update  input  1  single-cycle request to close the current window and snapshot it.
- cnt_sel  input  SEL_W  selects which bit's snapshotted count appears on cnt_out.
- snap_out  output  WIDTH  bits that saw at least one event in the last closed window.
- overrun_out  output  WIDTH  bits that saw two or more events in the last closed window.
- snap_valid  output  1  one-cycle pulse marking a new snapshot.
- cnt_out  output  CNT_W  snapshotted event count for bit cnt_sel.
- any_pending  output  1  OR of the live pending bits.

Behaviour:
- Reset (synchronous, reset high at a sys_clk edge):
  - Clears pending, ovr_pend, live counters, snap_out, overrun_out, snapshot counts, snap_valid and cnt_out.
  - Reset has priority over update and over events in the same cycle.
  - Reset in the middle of a window discards that window; no snap_valid is produced.
- Event ev[i] in a cycle without update:
  - If pending[i] is already 1, ovr_pend[i] <= 1.
  - pending[i] <= 1.
  - cnt[i] <= cnt[i] + 1, saturating at 2^CNT_W-1; it never wraps.
- Update cycle (update = 1 at edge T):
  - snap_out <= pending, overrun_out <= ovr_pend, snap_cnt[i] <= cnt[i]. All take the values held before edge T.
  - Events in the update cycle belong to the new window: pending <= ev, ovr_pend <= 0, cnt[i] <= ev[i] ? 1 : 0.
  - snap_valid = 1 for exactly the one cycle after edge T, alongside the new snap_out and overrun_out. Latency from update to snapshot is 1 cycle.
- Snapshot hold: snap_out, overrun_out and snap_cnt hold until the next update or reset.
- Back-to-back updates on consecutive cycles:
  - Each update produces its own snapshot and snap_valid pulse, so snap_valid stays high for two cycles.
  - The second snapshot holds only the events from the first update cycle.
- Update with no events in the window: snapshot is all zeros and snap_valid still pulses.
- cnt_out:
  - Registered: cnt_out <= snap_cnt[cnt_sel], 1-cycle latency from a cnt_sel change.
  - cnt_sel >= WIDTH reads 0.
  - After an update, cnt_out reflects the new counts 2 cycles after edge T.
- any_pending: combinational OR of the pending registers; no extra latency beyond the registers.
- Invariant: overrun_out[i] = 1 implies snap_out[i] = 1 and snap_cnt[i] >= 2.

Optional Feature:
- Macro: TRIGCAP_EDGE_EN.
- Defined:
  - ev_in is registered once per bit (ev_d).
  - An event is ev_in[i] & ~ev_d[i], i.e. a rising edge only; a held-high input counts once.
  - ev_d resets to 0, so an input already high when reset releases counts as an event on the first cycle after reset.
  - This adds no latency beyond the edge register.
- Not defined:
  - An event is ev_in[i] = 1 in a given cycle.
  - A level held for N cycles counts N events, with saturation.

Test Plan:
1. Reset, then pulse ev_in = 16'h0005 for one cycle, then update -> next cycle snap_valid = 1, snap_out = 16'h0005, overrun_out = 0; with cnt_sel = 0, cnt_out = 1 two cycles after update; any_pending = 0 after update.
2. Pulse ev_in[3] three times on separate cycles, then update -> snap_out = 16'h0008, overrun_out = 16'h0008, cnt_out (cnt_sel = 3) = 3.
3. Hold ev_in[1] = 1 for 300 cycles (macro off), then update -> cnt_out (cnt_sel = 1) = 255, saturated and not 44. With TRIGCAP_EDGE_EN defined, the same stimulus gives 1 and overrun_out[1] = 0.
4. Assert ev_in[2] in the same cycle as update, then assert a second update 5 cycles later -> first snapshot bit 2 = 0; second snapshot bit 2 = 1 with count 1.
5. Assert update on two consecutive cycles with ev_in = 0 -> snap_valid high for two cycles, both snapshots zero.
6. Pulse ev_in[0] twice, then reset together with update in the same cycle -> snap_valid stays 0, all outputs 0, any_pending = 0.
